// File: rtl/stream_transpose.sv
// stream_transpose: element-serial MxN matrix buffer with a per-matrix choice
// between transposed (column-major) and pass-through (row-major) readout.
// Optional feature macro: STREAM_TRANSPOSE_PINGPONG_EN
//   defined   -> two banks, load of one bank overlaps drain of the other
//   undefined -> one bank sequenced by a LOAD/DRAIN state machine
module stream_transpose #(
    parameter int unsigned M          = 2,
    parameter int unsigned N          = 2,
    parameter int unsigned DATA_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  trans,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

`ifdef STREAM_TRANSPOSE_PINGPONG_EN
    localparam int unsigned NB = 2;
`else
    localparam int unsigned NB = 1;
`endif
    localparam int unsigned DEPTH = M * N;
    localparam int unsigned RW    = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned CW    = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [RW-1:0] ROW_MAX = RW'(M - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(N - 1);

    logic [DATA_WIDTH-1:0] mem  [NB][DEPTH];
    logic                  mode [NB];

    logic          wr_bank;
    logic          rd_bank;
    logic [RW-1:0] wr_row;
    logic [CW-1:0] wr_col;
    logic [RW-1:0] rd_row;
    logic [CW-1:0] rd_col;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          in_fire;
    logic          out_fire;
    logic          wr_last;
    logic          rd_last;
    logic          rd_mode;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign wr_last  = (wr_row == ROW_MAX) && (wr_col == COL_MAX);
    assign rd_last  = (rd_row == ROW_MAX) && (rd_col == COL_MAX);
    assign wr_addr  = AW'(32'(wr_row) * N + 32'(wr_col));
    assign rd_addr  = AW'(32'(rd_row) * N + 32'(rd_col));
    assign rd_mode  = mode[rd_bank];

    // Both read orders end on A[M-1][N-1], so one last-detect serves both modes
    assign out_data = mem[rd_bank][rd_addr];
    assign out_last = out_valid && rd_last;

    // Element storage and per-bank mode capture; contents survive reset
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem[wr_bank][wr_addr] <= in_data;
            if ((wr_row == '0) && (wr_col == '0)) begin
                mode[wr_bank] <= trans;
            end
        end
    end

    // Write counters advance row-major; read counters follow the bank's latched mode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_row <= '0;
            wr_col <= '0;
            rd_row <= '0;
            rd_col <= '0;
        end else begin
            if (in_fire) begin
                if (wr_col == COL_MAX) begin
                    wr_col <= '0;
                    wr_row <= (wr_row == ROW_MAX) ? '0 : wr_row + 1'b1;
                end else begin
                    wr_col <= wr_col + 1'b1;
                end
            end
            if (out_fire) begin
                if (rd_mode) begin
                    if (rd_row == ROW_MAX) begin
                        rd_row <= '0;
                        rd_col <= (rd_col == COL_MAX) ? '0 : rd_col + 1'b1;
                    end else begin
                        rd_row <= rd_row + 1'b1;
                    end
                end else begin
                    if (rd_col == COL_MAX) begin
                        rd_col <= '0;
                        rd_row <= (rd_row == ROW_MAX) ? '0 : rd_row + 1'b1;
                    end else begin
                        rd_col <= rd_col + 1'b1;
                    end
                end
            end
        end
    end

`ifdef STREAM_TRANSPOSE_PINGPONG_EN
    logic [NB-1:0] full;
    logic          live;

    // live keeps in_ready low through reset; the full flags do the rest
    assign in_ready  = live && !full[wr_bank];
    assign out_valid = full[rd_bank];

    // Bank flags: filling marks the write bank full and moves to the other bank,
    // draining clears the read bank and moves on; the two never target the same bank
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            live    <= 1'b0;
        end else begin
            live <= 1'b1;
            if (in_fire && wr_last) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end
            if (out_fire && rd_last) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end
`else
    typedef enum logic {
        LOAD,
        DRAIN
    } state_t;

    state_t state;
    logic   in_ready_q;
    logic   out_valid_q;

    assign wr_bank   = 1'b0;
    assign rd_bank   = 1'b0;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

    // LOAD/DRAIN sequencing with registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= LOAD;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_fire && wr_last) begin
                        state       <= DRAIN;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        in_ready_q  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_fire && rd_last) begin
                        state       <= LOAD;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= LOAD;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_stream_transpose.sv
// tb_stream_transpose: scoreboard bench for stream_transpose (2x3 and 1x4 instances).
// Honours STREAM_TRANSPOSE_PINGPONG_EN when the same define is given to the bench.
module tb_stream_transpose;

    localparam int unsigned TM = 2;
    localparam int unsigned TN = 3;
`ifdef STREAM_TRANSPOSE_PINGPONG_EN
    localparam int EXP_STALLS = 0;
`else
    localparam int EXP_STALLS = TM * TN;
`endif

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       trans;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    logic [7:0] d_in_data;
    logic       d_in_valid;
    logic       d_in_ready;
    logic       d_trans;
    logic [7:0] d_out_data;
    logic       d_out_valid;
    logic       d_out_ready;
    logic       d_out_last;

    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;
    int unsigned cyc_count = 0;

    stream_transpose #(.M(TM), .N(TN), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .trans(trans),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    stream_transpose #(.M(1), .N(4), .DATA_WIDTH(8)) dut_deg (
        .clk(clk), .rst_n(rst_n),
        .in_data(d_in_data), .in_valid(d_in_valid), .in_ready(d_in_ready), .trans(d_trans),
        .out_data(d_out_data), .out_valid(d_out_valid), .out_ready(d_out_ready), .out_last(d_out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_count <= cyc_count + 1;

    // Expected stream for an m x n matrix holding base, base+1, ... in row-major order
    function automatic void model_push(input int base, input bit mode, input int unsigned m,
                                       input int unsigned n);
        exp_t e;
        if (mode) begin
            for (int unsigned c = 0; c < n; c++)
                for (int unsigned r = 0; r < m; r++) begin
                    e.data = 8'(base + int'(r * n + c));
                    e.last = (r == m - 1) && (c == n - 1);
                    sb.push_back(e);
                end
        end else begin
            for (int unsigned r = 0; r < m; r++)
                for (int unsigned c = 0; c < n; c++) begin
                    e.data = 8'(base + int'(r * n + c));
                    e.last = (r == m - 1) && (c == n - 1);
                    sb.push_back(e);
                end
        end
    endfunction

    // Drive count elements into the 2x3 instance; toggle flips trans after element 0
    task automatic send_matrix(input int base, input int count, input bit mode, input bit toggle,
                               input bit hold, output bit ok, output int stalls,
                               output int unsigned last_cyc);
        int k = 0;
        int guard = 0;
        stalls = 0;
        last_cyc = 0;
        while (k < count && guard < 200) begin
            @(negedge clk);
            guard++;
            in_valid = 1'b1;
            in_data  = 8'(base + k);
            trans    = (toggle && k != 0) ? ~mode : mode;
            if (in_ready) begin
                k++;
                last_cyc = cyc_count;
            end else begin
                stalls++;
            end
        end
        ok = (k == count);
        if (!hold) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; trans = 1'b0; out_ready = 1'b1;
        d_in_valid = 1'b0; d_in_data = '0; d_trans = 1'b0; d_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        else passes++;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        else passes++;
        checks++;
        if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b expected 0", out_last);
        else passes++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %b expected 1", in_ready);
        else passes++;
    endtask

    task automatic test_transpose();
        bit ok;
        int stalls;
        int unsigned last_cyc;
        int unsigned first_cyc = 0;
        bit seen = 1'b0;
        int got = 0;
        int guard = 0;
        exp_t e;
        model_push(1, 1'b1, TM, TN);
        out_ready = 1'b1;
        fork
            send_matrix(1, 6, 1'b1, 1'b0, 1'b0, ok, stalls, last_cyc);
            begin
                while (got < 6 && guard < 200) begin
                    @(negedge clk);
                    guard++;
                    if (out_valid && !seen) begin
                        seen = 1'b1;
                        first_cyc = cyc_count;
                    end
                    if (out_valid && out_ready && sb.size() > 0) begin
                        e = sb.pop_front();
                        got++;
                        checks++;
                        if (out_data !== e.data || out_last !== e.last)
                            $display("FAIL transpose_out[%0d]: got data=%0d last=%b expected data=%0d last=%b",
                                     got - 1, out_data, out_last, e.data, e.last);
                        else passes++;
                    end
                end
            end
        join
        checks++;
        if (!ok || got != 6) $display("FAIL transpose_timeout: inputs_ok=%b outputs=%0d expected 6", ok, got);
        else passes++;
        checks++;
        if (!seen || first_cyc != last_cyc + 1)
            $display("FAIL transpose_latency: out_valid at cycle %0d expected %0d", first_cyc, last_cyc + 1);
        else passes++;
    endtask

    task automatic test_passthrough();
        bit ok;
        int stalls;
        int unsigned last_cyc;
        int got = 0;
        int guard = 0;
        exp_t e;
        model_push(1, 1'b0, TM, TN);
        out_ready = 1'b1;
        fork
            send_matrix(1, 6, 1'b0, 1'b1, 1'b0, ok, stalls, last_cyc);
            begin
                while (got < 6 && guard < 200) begin
                    @(negedge clk);
                    guard++;
                    if (out_valid && out_ready && sb.size() > 0) begin
                        e = sb.pop_front();
                        got++;
                        checks++;
                        if (out_data !== e.data || out_last !== e.last)
                            $display("FAIL passthrough_out[%0d]: got data=%0d last=%b expected data=%0d last=%b",
                                     got - 1, out_data, out_last, e.data, e.last);
                        else passes++;
                    end
                end
            end
        join
        checks++;
        if (!ok || got != 6) $display("FAIL passthrough_timeout: inputs_ok=%b outputs=%0d expected 6", ok, got);
        else passes++;
    endtask

    task automatic test_backpressure();
        bit ok;
        int stalls;
        int unsigned last_cyc;
        int got = 0;
        int guard = 0;
        int held = 0;
        exp_t e;
        model_push(1, 1'b1, TM, TN);
        out_ready = 1'b1;
        fork
            send_matrix(1, 6, 1'b1, 1'b0, 1'b0, ok, stalls, last_cyc);
            begin
                while (got < 6 && guard < 200) begin
                    @(negedge clk);
                    guard++;
                    if (got == 3 && held < 3 && out_valid) begin
                        out_ready = 1'b0;
                        held++;
                        e = sb[0];
                        checks++;
                        if (out_valid !== 1'b1 || out_data !== e.data || out_last !== e.last)
                            $display("FAIL backpressure_hold[%0d]: got valid=%b data=%0d last=%b expected valid=1 data=%0d last=%b",
                                     held, out_valid, out_data, out_last, e.data, e.last);
                        else passes++;
                    end else begin
                        out_ready = 1'b1;
                    end
                    if (out_valid && out_ready && sb.size() > 0) begin
                        e = sb.pop_front();
                        got++;
                        checks++;
                        if (out_data !== e.data || out_last !== e.last)
                            $display("FAIL backpressure_out[%0d]: got data=%0d last=%b expected data=%0d last=%b",
                                     got - 1, out_data, out_last, e.data, e.last);
                        else passes++;
                    end
                end
            end
        join
        out_ready = 1'b1;
        checks++;
        if (!ok || got != 6 || held != 3)
            $display("FAIL backpressure_timeout: inputs_ok=%b outputs=%0d stalls=%0d expected 6 outputs 3 stalls",
                     ok, got, held);
        else passes++;
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2;
        int s1, s2;
        int unsigned lc1, lc2;
        int got = 0;
        int guard = 0;
        exp_t e;
        model_push(1, 1'b1, TM, TN);
        model_push(7, 1'b1, TM, TN);
        out_ready = 1'b1;
        fork
            begin
                send_matrix(1, 6, 1'b1, 1'b0, 1'b1, ok1, s1, lc1);
                send_matrix(7, 6, 1'b1, 1'b0, 1'b0, ok2, s2, lc2);
            end
            begin
                while (got < 12 && guard < 300) begin
                    @(negedge clk);
                    guard++;
                    if (out_valid && out_ready && sb.size() > 0) begin
                        e = sb.pop_front();
                        got++;
                        checks++;
                        if (out_data !== e.data || out_last !== e.last)
                            $display("FAIL b2b_out[%0d]: got data=%0d last=%b expected data=%0d last=%b",
                                     got - 1, out_data, out_last, e.data, e.last);
                        else passes++;
                    end
                end
            end
        join
        checks++;
        if (!ok1 || !ok2 || got != 12)
            $display("FAIL b2b_timeout: inputs_ok=%b%b outputs=%0d expected 12", ok1, ok2, got);
        else passes++;
        checks++;
        if (s1 + s2 != EXP_STALLS)
            $display("FAIL b2b_in_ready_low_cycles: got %0d expected %0d", s1 + s2, EXP_STALLS);
        else passes++;
    endtask

    task automatic test_reset_mid_load();
        bit ok;
        int stalls;
        int unsigned last_cyc;
        int got = 0;
        int guard = 0;
        int extra = 0;
        exp_t e;
        out_ready = 1'b1;
        send_matrix(1, 3, 1'b1, 1'b0, 1'b0, ok, stalls, last_cyc);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL midreset_outputs: got in_ready=%b out_valid=%b expected 0 0", in_ready, out_valid);
        else passes++;
        rst_n = 1'b1;
        model_push(10, 1'b1, TM, TN);
        fork
            send_matrix(10, 6, 1'b1, 1'b0, 1'b0, ok, stalls, last_cyc);
            begin
                while (got < 6 && guard < 200) begin
                    @(negedge clk);
                    guard++;
                    if (out_valid && out_ready && sb.size() > 0) begin
                        e = sb.pop_front();
                        got++;
                        checks++;
                        if (out_data !== e.data || out_last !== e.last)
                            $display("FAIL midreset_out[%0d]: got data=%0d last=%b expected data=%0d last=%b",
                                     got - 1, out_data, out_last, e.data, e.last);
                        else passes++;
                    end
                end
            end
        join
        checks++;
        if (!ok || got != 6) $display("FAIL midreset_timeout: inputs_ok=%b outputs=%0d expected 6", ok, got);
        else passes++;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        checks++;
        if (extra != 0) $display("FAIL midreset_leftover: got %0d valid cycles expected 0", extra);
        else passes++;
    endtask

    task automatic test_degenerate();
        int k = 0;
        int guard_in = 0;
        int got = 0;
        int guard = 0;
        exp_t e;
        model_push(1, 1'b1, 1, 4);
        d_out_ready = 1'b1;
        fork
            begin
                while (k < 4 && guard_in < 200) begin
                    @(negedge clk);
                    guard_in++;
                    d_in_valid = 1'b1;
                    d_in_data  = 8'(k + 1);
                    d_trans    = 1'b1;
                    if (d_in_ready) k++;
                end
                @(negedge clk);
                d_in_valid = 1'b0;
            end
            begin
                while (got < 4 && guard < 200) begin
                    @(negedge clk);
                    guard++;
                    if (d_out_valid && d_out_ready && sb.size() > 0) begin
                        e = sb.pop_front();
                        got++;
                        checks++;
                        if (d_out_data !== e.data || d_out_last !== e.last)
                            $display("FAIL degenerate_out[%0d]: got data=%0d last=%b expected data=%0d last=%b",
                                     got - 1, d_out_data, d_out_last, e.data, e.last);
                        else passes++;
                    end
                end
            end
        join
        checks++;
        if (k != 4 || got != 4) $display("FAIL degenerate_timeout: inputs=%0d outputs=%0d expected 4 4", k, got);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_transpose();
        test_passthrough();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_load();
        test_degenerate();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/stream_transpose.md
# stream_transpose

Sequential, streaming successor to the combinational matrix transposer. Accepts an MxN matrix one element per handshake in row-major order, buffers it, and emits it one element per handshake. Output order is either transposed (column-major of the input, i.e. row-major NxM) or pass-through, selected per matrix. Sits between element-serial producers and consumers in the matrix datapath, where full-width flattened buses are too wide to route.

## Interface
- `M`, default 2: input matrix rows, ≥1.
- `N`, default 2: input matrix columns, ≥1.
- `DATA_WIDTH`, default 2: bits per element, ≥1.

- `clk`, input, 1: single clock; all logic on its rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `in_data`, input, DATA_WIDTH: input element.
- `in_valid`, input, 1: `in_data` valid.
- `in_ready`, output, 1: block can accept.
- `trans`, input, 1: mode, 1 = transpose, 0 = pass-through. Sampled on the first element of each matrix.
- `out_data`, output, DATA_WIDTH: output element.
- `out_valid`, output, 1: `out_data` valid.
- `out_ready`, input, 1: consumer accepts.
- `out_last`, output, 1: current output element is the last of its matrix.

## Operation
- Handshake: transfer occurs when valid && ready on a rising edge. Input element k (0-based) is A[k/N][k%N].
- Storage: a bank of M*N registers of DATA_WIDTH bits. A row counter (0..M-1) and a column counter (0..N-1) address writes; the column counter wraps and increments the row.
- Each bank has a full flag and a latched mode bit. The mode is captured from `trans` on the handshake of element 0.
- A bank is full after element M*N-1 is accepted.
- Read order:
  - Transpose: for c in 0..N-1, for r in 0..M-1, emit A[r][c].
  - Pass-through: row-major A.
  - Read counters wrap the same way as the write counters.
- `out_last` is high exactly when the read index is M*N-1 and `out_valid` is high.
- The bank's full flag clears on the handshake of its last element.
- Single-bank mode (macro absent) has two states:
  - LOAD: `in_ready`=1, `out_valid`=0.
  - DRAIN: `in_ready`=0, `out_valid`=1.
  - LOAD→DRAIN on the last input handshake. DRAIN→LOAD on the last output handshake.
- Backpressure: while `out_valid` && !`out_ready`, `out_data` and `out_last` hold stable. The producer may deassert `in_valid` at any time with no effect on state.
- Degenerate M=1 or N=1: both modes emit identical order. Counters must not overflow; a 1-wide counter stays 0.
- Reset when `rst_n`=0 at an edge:
  - All counters, full flags and the state return to LOAD/empty.
  - A partial matrix, input or output, is discarded.
  - Storage contents are not cleared.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `in_ready`=0 while `rst_n` is low. `in_ready`=1 from the first cycle after release. `out_data` is don't-care while `out_valid`=0.
- Latency: `out_valid` rises the cycle after the last input handshake of a matrix. `out_data` is a combinational read of the registered bank at the registered read index.
- Single bank: `in_ready` is low from the cycle after the last input handshake until the cycle after the last output handshake. Minimum period per matrix is 2*M*N cycles.
- `in_ready`, `out_valid` and `out_last` derive from registers only. No combinational path runs from `in_valid` or `out_ready` to any output.

## Configuration
- `STREAM_TRANSPOSE_PINGPONG_EN` defined: two banks with independent write and read bank pointers.
  - Write pointer toggles when a bank fills; read pointer toggles when a bank drains.
  - `in_ready` = !full[wr_bank]; `out_valid` = full[rd_bank].
  - Loading one bank while draining the other is allowed in the same cycle.
  - With `out_ready` held high, throughput is 1 element/cycle sustained and `in_ready` never drops.
  - Mode is latched per bank.
- Undefined: single bank, LOAD/DRAIN behaviour as above.

## Test plan
- Transpose basic: M=2, N=3, DATA_WIDTH=8, trans=1, input 1..6, `out_ready`=1 → output 1,4,2,5,3,6; `out_last` only with 6; `out_valid` rises the cycle after input 6.
- Pass-through: same stimulus with trans=0 → output 1,2,3,4,5,6. Toggling `trans` mid-matrix has no effect.
- Backpressure: `out_ready` low for 3 cycles while element 5 is presented → `out_data`=5 held stable, then order resumes 3,6.
- Back-to-back matrices 1..6 then 7..12, `out_ready`=1:
  - With the macro: `in_ready` stays 1 for all 12 inputs; output 1,4,2,5,3,6,7,10,8,11,9,12.
  - Without the macro: `in_ready` is low for 6 cycles between matrices.
- Reset mid-load: accept 1,2,3, assert `rst_n`=0 for one cycle, then send 10..15 → output 10,13,11,14,12,15; nothing from 1..3 appears.
- Degenerate M=1, N=4, trans=1, input 1..4 → output 1,2,3,4; `out_last` with 4.
